// File: rtl/tm1638_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// tm1638_frame_tx_pkg
// Shared definitions for the TM1638 write-frame transmitter.
//   - TM1638 command bytes (data write with auto-increment, address 0,
//     display-control base)
//   - special glyph codes understood by the segment decoder
//   - 5-bit digit code type and FSM state type
//   - frame layout constants (byte indices inside one 19-byte frame)
// ---------------------------------------------------------------------------
package tm1638_frame_tx_pkg;

   typedef logic [4:0] digit_code_t;

   localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
   localparam logic [7:0] CMD_ADDR0     = 8'hC0;
   localparam logic [7:0] CMD_DISP_BASE = 8'h80;

   localparam digit_code_t GLYPH_BLANK = 5'd16;
   localparam digit_code_t GLYPH_DASH  = 5'd17;

   // A frame is C1 (byte 0), C2 (address byte 1 plus data bytes 2..17)
   // and C3 (byte 18); the strobe is released after each command's last byte.
   localparam logic [4:0] LAST_C1     = 5'd0;
   localparam logic [4:0] LAST_C2     = 5'd17;
   localparam logic [4:0] LAST_C3     = 5'd18;
   localparam logic [4:0] FRAME_BYTES = 5'd19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STB_SETUP,
      ST_SHIFT,
      ST_STB_GAP,
      ST_DONE
   } state_t;

   // Display-control command: enable bit and 3-bit pulse width.
   function automatic logic [7:0] dispCmd(input logic on, input logic [2:0] bright);
      return CMD_DISP_BASE | {4'b0000, on, bright};
   endfunction

endpackage

// File: rtl/tm1638_frame_tx_if.sv
// ---------------------------------------------------------------------------
// tm1638_frame_tx_if
// Bundles the frame request/content inputs, the status outputs and the
// three TM1638 pins of the transmitter.
//   master : upstream pattern/digit source (drives request and content,
//            observes status and pins)
//   slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface tm1638_frame_tx_if;

   logic        start;
   logic [7:0]  led_in;
   logic [39:0] digits_in;
   logic [2:0]  brightness;
   logic        display_on;
   logic        busy;
   logic        done;
   logic        sclk;
   logic        stb;
   logic        dio;

   modport master (
      output start, led_in, digits_in, brightness, display_on,
      input  busy, done, sclk, stb, dio
   );

   modport slave (
      input  start, led_in, digits_in, brightness, display_on,
      output busy, done, sclk, stb, dio
   );

endinterface

// File: rtl/tm1638_frame_tx_seg_decode.sv
// ---------------------------------------------------------------------------
// tm1638_seg_decode
// Combinational 5-bit digit code to 7-segment byte (bit0=a .. bit6=g,
// bit7=dp, always 0).
//   i_code : digit code; 0-15 hex glyphs, 16 blank, 17 dash, 18-31 blank
//   o_seg  : segment byte for the TM1638 even addresses
// ---------------------------------------------------------------------------
module tm1638_seg_decode
   import tm1638_frame_tx_pkg::*;
(
   input  digit_code_t i_code,
   output logic [7:0]  o_seg
);

   // Glyph lookup; anything outside the hex range and the dash is blank.
   always_comb begin
      o_seg = 8'h00;
      case (i_code)
         5'd0:       o_seg = 8'h3F;
         5'd1:       o_seg = 8'h06;
         5'd2:       o_seg = 8'h5B;
         5'd3:       o_seg = 8'h4F;
         5'd4:       o_seg = 8'h66;
         5'd5:       o_seg = 8'h6D;
         5'd6:       o_seg = 8'h7D;
         5'd7:       o_seg = 8'h07;
         5'd8:       o_seg = 8'h7F;
         5'd9:       o_seg = 8'h6F;
         5'd10:      o_seg = 8'h77;
         5'd11:      o_seg = 8'h7C;
         5'd12:      o_seg = 8'h39;
         5'd13:      o_seg = 8'h5E;
         5'd14:      o_seg = 8'h79;
         5'd15:      o_seg = 8'h71;
         GLYPH_BLANK: o_seg = 8'h00;
         GLYPH_DASH:  o_seg = 8'h40;
         default:    o_seg = 8'h00;
      endcase
   end

endmodule

// File: rtl/tm1638_frame_tx.sv
// ---------------------------------------------------------------------------
// tm1638_frame_tx
// Write-only TM1638 frame transmitter. On a trigger (start in IDLE or the
// auto-refresh timer) it snapshots LEDs, digits, brightness and enable, then
// sends three strobed commands LSB first: 0x40, 0xC0 + 16 data bytes,
// {1000, display_on, brightness}.
//   clk_50M : system clock
//   rst     : synchronous active-high reset
//   io_bus  : slave side of tm1638_frame_tx_if (start, led_in, digits_in,
//             brightness, display_on in; busy, done, sclk, stb, dio out)
// Parameters: CLK_DIV cycles per serial half-period, AUTO_REFRESH enable,
// REFRESH_GAP idle cycles between automatic frames.
// ---------------------------------------------------------------------------
module tm1638_frame_tx
   import tm1638_frame_tx_pkg::*;
#(
   parameter int CLK_DIV      = 25,
   parameter int AUTO_REFRESH = 1,
   parameter int REFRESH_GAP  = 50000
) (
   input  logic                clk_50M,
   input  logic                rst,
   tm1638_frame_tx_if.slave    io_bus
);

   localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
   localparam int REF_W = $clog2(REFRESH_GAP) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_GAP - 1);

   state_t            r_state;
   logic [DIV_W-1:0]  r_divCnt;
   logic              r_sclkHigh;
   logic [2:0]        r_bitIdx;
   logic [4:0]        r_byteIdx;
   logic [REF_W-1:0]  r_refreshCnt;
   logic [7:0]        r_led;
   logic [39:0]       r_digits;
   logic [2:0]        r_bright;
   logic              r_dispOn;

   state_t            w_nextState;
   logic [DIV_W-1:0]  w_nextDivCnt;
   logic              w_nextSclkHigh;
   logic [2:0]        w_nextBitIdx;
   logic [4:0]        w_nextByteIdx;
   logic              w_autoFire;
   logic              w_trigger;
   logic              w_lastOfCmd;
   logic [3:0]        w_dataIdx;
   logic [2:0]        w_digitSel;
   logic [5:0]        w_digitBase;
   digit_code_t       w_digitCode;
   logic [7:0]        w_segByte;
   logic [7:0]        w_curByte;
   logic              w_busy;
   logic              w_done;
   logic              w_sclk;
   logic              w_stb;
   logic              w_dio;

   // A frame starts from IDLE either on request or when the refresh timer
   // has counted the full gap; both paths behave identically afterwards.
   assign w_autoFire  = (AUTO_REFRESH != 0) && (r_refreshCnt == REF_LAST);
   assign w_trigger   = (r_state == ST_IDLE) && (io_bus.start || w_autoFire);
   assign w_lastOfCmd = (r_byteIdx == LAST_C1) || (r_byteIdx == LAST_C2) ||
                        (r_byteIdx == LAST_C3);

   // Data bytes 2..17 alternate segment byte / LED byte for digit index
   // (byte-2)/2, so one decoder on a muxed digit code serves all eight.
   assign w_dataIdx   = 4'(r_byteIdx - 5'd2);
   assign w_digitSel  = w_dataIdx[3:1];
   assign w_digitBase = 6'(w_digitSel) * 6'd5;
   assign w_digitCode = r_digits[w_digitBase +: 5];

   tm1638_seg_decode u_segDecode (
      .i_code (w_digitCode),
      .o_seg  (w_segByte)
   );

   // Selects the byte currently being shifted out from the frame layout.
   always_comb begin
      w_curByte = 8'h00;
      case (r_byteIdx)
         5'd0:    w_curByte = CMD_DATA_AUTO;
         5'd1:    w_curByte = CMD_ADDR0;
         LAST_C3: w_curByte = dispCmd(r_dispOn, r_bright);
         default: w_curByte = w_dataIdx[0] ? {7'b0000000, r_led[w_digitSel]} : w_segByte;
      endcase
   end

   // State and serial position registers; reset drops straight back to IDLE
   // so a frame cut short never produces a done pulse.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_divCnt   <= '0;
         r_sclkHigh <= 1'b1;
         r_bitIdx   <= '0;
         r_byteIdx  <= '0;
      end else begin
         r_state    <= w_nextState;
         r_divCnt   <= w_nextDivCnt;
         r_sclkHigh <= w_nextSclkHigh;
         r_bitIdx   <= w_nextBitIdx;
         r_byteIdx  <= w_nextByteIdx;
      end
   end

   // Next-state logic and pin outputs. Each serial bit is a low phase (dio
   // changes as it begins) followed by a high phase of CLK_DIV cycles each,
   // so dio is already stable when the TM1638 samples on the rising edge.
   always_comb begin
      w_nextState    = r_state;
      w_nextDivCnt   = r_divCnt;
      w_nextSclkHigh = r_sclkHigh;
      w_nextBitIdx   = r_bitIdx;
      w_nextByteIdx  = r_byteIdx;
      w_busy         = 1'b0;
      w_done         = 1'b0;
      w_sclk         = 1'b1;
      w_stb          = 1'b1;
      w_dio          = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (w_trigger) begin
               w_nextState   = ST_STB_SETUP;
               w_nextDivCnt  = '0;
               w_nextBitIdx  = '0;
               w_nextByteIdx = '0;
            end
         end
         ST_STB_SETUP: begin
            w_busy = 1'b1;
            w_stb  = 1'b0;
            if (r_divCnt == DIV_LAST) begin
               w_nextState    = ST_SHIFT;
               w_nextDivCnt   = '0;
               w_nextSclkHigh = 1'b0;
               w_nextBitIdx   = '0;
            end else begin
               w_nextDivCnt = r_divCnt + 1'b1;
            end
         end
         ST_SHIFT: begin
            w_busy = 1'b1;
            w_stb  = 1'b0;
            w_sclk = r_sclkHigh;
            w_dio  = w_curByte[r_bitIdx];
            if (r_divCnt == DIV_LAST) begin
               w_nextDivCnt = '0;
               if (!r_sclkHigh) begin
                  w_nextSclkHigh = 1'b1;
               end else begin
                  w_nextSclkHigh = 1'b0;
                  if (r_bitIdx == 3'd7) begin
                     w_nextBitIdx  = '0;
                     w_nextByteIdx = r_byteIdx + 1'b1;
                     if (w_lastOfCmd) begin
                        w_nextState    = ST_STB_GAP;
                        w_nextSclkHigh = 1'b1;
                     end
                  end else begin
                     w_nextBitIdx = r_bitIdx + 1'b1;
                  end
               end
            end else begin
               w_nextDivCnt = r_divCnt + 1'b1;
            end
         end
         ST_STB_GAP: begin
            w_busy = 1'b1;
            if (r_divCnt == GAP_LAST) begin
               w_nextDivCnt = '0;
               w_nextState  = (r_byteIdx == FRAME_BYTES) ? ST_DONE : ST_STB_SETUP;
            end else begin
               w_nextDivCnt = r_divCnt + 1'b1;
            end
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Snapshot of the frame content on the trigger edge; the frame in flight
   // never sees later input changes.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         r_led    <= '0;
         r_digits <= '0;
         r_bright <= '0;
         r_dispOn <= 1'b0;
      end else if (w_trigger) begin
         r_led    <= io_bus.led_in;
         r_digits <= io_bus.digits_in;
         r_bright <= io_bus.brightness;
         r_dispOn <= io_bus.display_on;
      end
   end

   // Refresh timer: counts idle cycles from reset or from the done cycle,
   // restarts on any trigger and holds while a frame is running.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         r_refreshCnt <= '0;
      end else if (r_state == ST_DONE) begin
         r_refreshCnt <= '0;
      end else if (r_state == ST_IDLE) begin
         if (w_trigger) begin
            r_refreshCnt <= '0;
         end else if (r_refreshCnt != REF_LAST) begin
            r_refreshCnt <= r_refreshCnt + 1'b1;
         end
      end
   end

   assign io_bus.busy = w_busy;
   assign io_bus.done = w_done;
   assign io_bus.sclk = w_sclk;
   assign io_bus.stb  = w_stb;
   assign io_bus.dio  = w_dio;

endmodule

// File: tb/tb_tm1638_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_tm1638_frame_tx
// Self-checking bench for tm1638_frame_tx. Three instances cover the
// configurations of interest: A (CLK_DIV=2, manual), B (CLK_DIV=3, manual),
// C (CLK_DIV=1, auto refresh every 10 idle cycles). Frames are decoded from
// the pins and compared with a byte list built from the TM1638 frame rules.
// ---------------------------------------------------------------------------
module tb_tm1638_frame_tx;

   logic       clk = 1'b0;
   logic [2:0] rstV;

   tm1638_frame_tx_if ifA ();
   tm1638_frame_tx_if ifB ();
   tm1638_frame_tx_if ifC ();

   tm1638_frame_tx #(.CLK_DIV(2), .AUTO_REFRESH(0), .REFRESH_GAP(50000)) dutA (
      .clk_50M (clk), .rst (rstV[0]), .io_bus (ifA.slave));
   tm1638_frame_tx #(.CLK_DIV(3), .AUTO_REFRESH(0), .REFRESH_GAP(50000)) dutB (
      .clk_50M (clk), .rst (rstV[1]), .io_bus (ifB.slave));
   tm1638_frame_tx #(.CLK_DIV(1), .AUTO_REFRESH(1), .REFRESH_GAP(10)) dutC (
      .clk_50M (clk), .rst (rstV[2]), .io_bus (ifC.slave));

   always #5 clk = ~clk;

   logic [2:0] mStb, mSclk, mDio, mBusy, mDone;
   assign mStb  = {ifC.stb,  ifB.stb,  ifA.stb};
   assign mSclk = {ifC.sclk, ifB.sclk, ifA.sclk};
   assign mDio  = {ifC.dio,  ifB.dio,  ifA.dio};
   assign mBusy = {ifC.busy, ifB.busy, ifA.busy};
   assign mDone = {ifC.done, ifB.done, ifA.done};

   int cdOf [3] = '{2, 3, 1};

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] hexGlyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   logic [7:0] expBytes [$];
   bit         capBits [$];
   int         capWin [$];
   int         capBusy, capDone, capTimErr;
   bit         capTimeout, capDoneEnd, capDoneAfter;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives frame content onto one instance's interface.
   task automatic applyStimulus(input int sel, input logic [7:0] led, input logic [39:0] dig,
                                input logic [2:0] br, input logic dp);
      case (sel)
         0: begin ifA.led_in = led; ifA.digits_in = dig; ifA.brightness = br; ifA.display_on = dp; end
         1: begin ifB.led_in = led; ifB.digits_in = dig; ifB.brightness = br; ifB.display_on = dp; end
         default: begin ifC.led_in = led; ifC.digits_in = dig; ifC.brightness = br; ifC.display_on = dp; end
      endcase
   endtask

   task automatic setStart(input int sel, input logic v);
      case (sel)
         0: ifA.start = v;
         1: ifB.start = v;
         default: ifC.start = v;
      endcase
   endtask

   task automatic pulseStart(input int sel);
      setStart(sel, 1'b1);
      @(posedge clk); #1;
      setStart(sel, 1'b0);
   endtask

   function automatic logic [7:0] glyphOf(input logic [4:0] code);
      if (code < 5'd16) return hexGlyph[code[3:0]];
      if (code == 5'd17) return 8'h40;
      return 8'h00;
   endfunction

   // Reference frame: three commands, digit i at address 2i, LED i at 2i+1.
   task automatic buildExpected(input logic [7:0] led, input logic [39:0] dig,
                                input logic [2:0] br, input logic dp);
      expBytes.delete();
      expBytes.push_back(8'h40);
      expBytes.push_back(8'hC0);
      for (int i = 0; i < 8; i++) begin
         expBytes.push_back(glyphOf(dig[5*i +: 5]));
         expBytes.push_back({7'b0, led[i]});
      end
      expBytes.push_back({4'b1000, dp, br});
   endtask

   // Follows one frame on the pins of instance sel: collects bits on sclk
   // rises under stb low and measures every phase length.
   task automatic captureFrame(input int sel, input int budget);
      int  n, lowRun, highRun, stbHighRun, winBits, cd;
      bit  prevSclk, prevStb, fallDio;
      capBits.delete(); capWin.delete();
      capBusy = 0; capDone = 0; capTimErr = 0; capTimeout = 0;
      capDoneEnd = 0; capDoneAfter = 0;
      cd = cdOf[sel];
      n = 0;
      while (!mBusy[sel] && n < budget) begin
         @(posedge clk); #1; n++;
      end
      if (!mBusy[sel]) begin
         capTimeout = 1;
         return;
      end
      prevSclk = 1; prevStb = 1; fallDio = 1;
      lowRun = 0; highRun = 0; stbHighRun = 0; winBits = 0;
      while (mBusy[sel] && n < budget) begin
         capBusy++;
         if (mDone[sel]) capDone++;
         if (!mStb[sel]) begin
            if (prevStb) begin
               if (stbHighRun != 0 && stbHighRun != 2 * cd) capTimErr++;
               stbHighRun = 0;
               winBits = 0;
            end
            if (mSclk[sel]) begin
               if (!prevSclk) begin
                  capBits.push_back(mDio[sel]);
                  winBits++;
                  if (mDio[sel] != fallDio) capTimErr++;
                  if (lowRun != cd) capTimErr++;
                  lowRun = 0;
               end
               highRun++;
            end else begin
               if (prevSclk) begin
                  if (highRun != cd) capTimErr++;
                  highRun = 0;
                  fallDio = mDio[sel];
               end else if (mDio[sel] != fallDio) begin
                  capTimErr++;
               end
               lowRun++;
            end
         end else begin
            if (!prevStb) begin
               if (highRun != cd) capTimErr++;
               highRun = 0;
               capWin.push_back(winBits);
            end
            if (!mSclk[sel] || !mDio[sel]) capTimErr++;
            stbHighRun++;
         end
         prevSclk = mSclk[sel];
         prevStb  = mStb[sel];
         @(posedge clk); #1; n++;
      end
      if (mBusy[sel]) begin
         capTimeout = 1;
         return;
      end
      if (stbHighRun != 2 * cd) capTimErr++;
      capDoneEnd = mDone[sel];
      @(posedge clk); #1;
      capDoneAfter = mDone[sel];
   endtask

   // Compares the last captured frame with expBytes and the timing rules.
   task automatic compareFrame(input string tag, input int sel);
      logic [7:0] b;
      checkOutput({tag, ".timeout"}, 64'(capTimeout), 64'd0);
      checkOutput({tag, ".bitCount"}, 64'(capBits.size()), 64'd152);
      if (capBits.size() == 152) begin
         for (int i = 0; i < 19; i++) begin
            for (int k = 0; k < 8; k++) b[k] = capBits[8 * i + k];
            checkOutput($sformatf("%s.byte%0d", tag, i), 64'(b), 64'(expBytes[i]));
         end
      end
      checkOutput({tag, ".cmdCount"}, 64'(capWin.size()), 64'd3);
      if (capWin.size() == 3) begin
         checkOutput({tag, ".c1Bits"}, 64'(capWin[0]), 64'd8);
         checkOutput({tag, ".c2Bits"}, 64'(capWin[1]), 64'd136);
         checkOutput({tag, ".c3Bits"}, 64'(capWin[2]), 64'd8);
      end
      checkOutput({tag, ".busyCycles"}, 64'(capBusy), 64'(313 * cdOf[sel]));
      checkOutput({tag, ".timing"}, 64'(capTimErr), 64'd0);
      checkOutput({tag, ".doneInBusy"}, 64'(capDone), 64'd0);
      checkOutput({tag, ".doneAtEnd"}, 64'(capDoneEnd), 64'd1);
      checkOutput({tag, ".doneOneCycle"}, 64'(capDoneAfter), 64'd0);
   endtask

   function automatic logic [4:0] idlePins(input int sel);
      return {mStb[sel], mSclk[sel], mDio[sel], mBusy[sel], mDone[sel]};
   endfunction

   initial begin
      logic [7:0]  led;
      logic [39:0] dig;
      logic [2:0]  br;
      logic        dp;
      int          n, busyCnt, doneCnt;

      rstV = 3'b111;
      for (int s = 0; s < 3; s++) begin
         setStart(s, 1'b0);
         applyStimulus(s, 8'h00, 40'h0, 3'd0, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++)
         checkOutput($sformatf("resetPins%0d", s), 64'(idlePins(s)), 64'h1C);
      rstV = 3'b000;
      @(posedge clk); #1;
      checkOutput("idlePinsA", 64'(idlePins(0)), 64'h1C);

      // Directed frame: LEDs 0 and 7 on, every digit shows 7.
      $display("[TB] directed frame on CLK_DIV=2");
      led = 8'h81; dig = {8{5'd7}}; br = 3'd7; dp = 1'b1;
      applyStimulus(0, led, dig, br, dp);
      buildExpected(led, dig, br, dp);
      pulseStart(0);
      captureFrame(0, 4000);
      compareFrame("directed", 0);

      // Bit timing on CLK_DIV=3 with random content.
      $display("[TB] timing frame on CLK_DIV=3");
      led = 8'($urandom); dig = 40'({$urandom, $urandom}); br = 3'($urandom); dp = 1'($urandom);
      applyStimulus(1, led, dig, br, dp);
      buildExpected(led, dig, br, dp);
      pulseStart(1);
      captureFrame(1, 6000);
      compareFrame("timing", 1);

      // Decode sweep on digit 0.
      $display("[TB] decode sweep");
      for (int code = 0; code <= 18; code++) begin
         led = 8'($urandom);
         dig = {35'({$urandom, $urandom}), 5'(code)};
         br = 3'($urandom); dp = 1'($urandom);
         applyStimulus(0, led, dig, br, dp);
         buildExpected(led, dig, br, dp);
         pulseStart(0);
         captureFrame(0, 4000);
         compareFrame($sformatf("code%0d", code), 0);
      end

      // Fully random frames, codes over the whole 0..31 range.
      for (int r = 0; r < 3; r++) begin
         led = 8'($urandom); dig = 40'({$urandom, $urandom}); br = 3'($urandom); dp = 1'($urandom);
         applyStimulus(0, led, dig, br, dp);
         buildExpected(led, dig, br, dp);
         repeat (2 + $urandom_range(0, 5)) @(posedge clk);
         #1;
         pulseStart(0);
         captureFrame(0, 4000);
         compareFrame($sformatf("random%0d", r), 0);
      end

      // start held high through a frame while content changes mid-frame.
      $display("[TB] start held during frame");
      led = 8'($urandom); dig = 40'({$urandom, $urandom}); br = 3'($urandom); dp = 1'($urandom);
      applyStimulus(0, led, dig, br, dp);
      buildExpected(led, dig, br, dp);
      setStart(0, 1'b1);
      fork
         captureFrame(0, 4000);
         begin : spam
            int c;
            c = 0;
            @(posedge clk); #1;
            while (!mDone[0] && c < 4000) begin
               c++;
               if (c == 100) applyStimulus(0, ~led, ~dig, ~br, ~dp);
               @(posedge clk); #1;
            end
            setStart(0, 1'b0);
         end
      join
      compareFrame("startHeld", 0);
      busyCnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (mBusy[0]) busyCnt++;
         @(posedge clk); #1;
      end
      checkOutput("noQueuedStart", 64'(busyCnt), 64'd0);

      // Reset in the middle of a frame.
      $display("[TB] reset mid-frame");
      led = 8'($urandom); dig = 40'({$urandom, $urandom}); br = 3'($urandom); dp = 1'($urandom);
      applyStimulus(0, led, dig, br, dp);
      pulseStart(0);
      for (int i = 1; i < 200; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("busyBeforeReset", 64'(mBusy[0]), 64'd1);
      rstV[0] = 1'b1;
      @(posedge clk); #1;
      checkOutput("pinsAfterReset", 64'(idlePins(0)), 64'h1C);
      rstV[0] = 1'b0;
      busyCnt = 0; doneCnt = 0;
      for (int i = 0; i < 700; i++) begin
         if (mBusy[0]) busyCnt++;
         if (mDone[0]) doneCnt++;
         @(posedge clk); #1;
      end
      checkOutput("noDoneAfterReset", 64'(doneCnt), 64'd0);
      checkOutput("idleAfterReset", 64'(busyCnt), 64'd0);
      led = 8'($urandom); dig = 40'({$urandom, $urandom}); br = 3'($urandom); dp = 1'($urandom);
      applyStimulus(0, led, dig, br, dp);
      buildExpected(led, dig, br, dp);
      pulseStart(0);
      captureFrame(0, 4000);
      compareFrame("afterReset", 0);

      // Auto refresh: REFRESH_GAP=10, CLK_DIV=1.
      $display("[TB] auto refresh");
      led = 8'($urandom); dig = 40'({$urandom, $urandom}); br = 3'($urandom); dp = 1'($urandom);
      applyStimulus(2, led, dig, br, dp);
      buildExpected(led, dig, br, dp);
      rstV[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstV[2] = 1'b0;
      n = 0;
      while (!mBusy[2] && n < 200) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("autoFirstDelay", 64'(n), 64'd10);
      for (int f = 0; f < 3; f++) begin
         captureFrame(2, 2000);
         compareFrame($sformatf("auto%0d", f), 2);
         n = 0;
         while (!mBusy[2] && n < 200) begin
            @(posedge clk); #1; n++;
         end
         checkOutput($sformatf("autoGap%0d", f), 64'(n), 64'd10);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
